// File: rtl/exc_vector_seq_if.sv
// Bus between the exception sequencer and the core datapath/control.
// The control side raises exception requests and supplies PC and memory
// data; the sequencer drives the EPC/PC write strobes, memory read and
// PC-mux selector.
interface exc_vector_seq_if;
    logic        exc_opcode;
    logic        exc_div0;
    logic        exc_ovf;
    logic [31:0] pc_cur;
    logic [7:0]  mem_byte;

    logic        busy;
    logic        done;
    logic [1:0]  cause;
    logic        epc_wr;
    logic [31:0] epc_data;
    logic        mem_rd;
    logic [31:0] mem_addr;
    logic        pc_wr;
    logic [2:0]  pc_src_sel;
    logic [31:0] handler_addr;

    // Core side: raises requests, consumes the sequencer strobes.
    modport master (
        output exc_opcode, exc_div0, exc_ovf, pc_cur, mem_byte,
        input  busy, done, cause, epc_wr, epc_data, mem_rd, mem_addr,
               pc_wr, pc_src_sel, handler_addr
    );

    // Sequencer side.
    modport slave (
        input  exc_opcode, exc_div0, exc_ovf, pc_cur, mem_byte,
        output busy, done, cause, epc_wr, epc_data, mem_rd, mem_addr,
               pc_wr, pc_src_sel, handler_addr
    );
endinterface

// File: rtl/exc_vector_seq.sv
// Multicycle exception sequencer.
// On an accepted exception it writes PC-4 into EPC, reads the handler byte
// from the cause's fixed vector address, and loads the zero-extended byte
// into PC through the memory-data leg of the PC mux. The main control FSM
// stalls while busy is high. Every output is either a register or a decode
// of the state register, so no input reaches an output combinationally.
module exc_vector_seq #(
    parameter logic [31:0] VEC_OPCODE = 32'd253,
    parameter logic [31:0] VEC_OVF    = 32'd254,
    parameter logic [31:0] VEC_DIV0   = 32'd255,
    // Wait cycles between the read request and data capture, 1..15.
    parameter int unsigned MEM_WAIT   = 2,
    parameter logic [2:0]  SEL_MEM    = 3'b101
) (
    input  logic              clk,
    input  logic              reset,
    exc_vector_seq_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SAVE_EPC = 3'd1,
        S_MEM_RD   = 3'd2,
        S_MEM_WAIT = 3'd3,
        S_LOAD_PC  = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    localparam logic [1:0] CAUSE_NONE   = 2'b00;
    localparam logic [1:0] CAUSE_OPCODE = 2'b01;
    localparam logic [1:0] CAUSE_DIV0   = 2'b10;
    localparam logic [1:0] CAUSE_OVF    = 2'b11;

    // The counter is preloaded with MEM_WAIT-1 so the capture happens on the
    // MEM_WAIT-th cycle spent in S_MEM_WAIT.
    localparam logic [3:0] WAIT_LOAD = 4'(MEM_WAIT - 1);

    state_t      state;
    state_t      state_nxt;

    logic [31:0] pc_lat;
    logic [31:0] vec_lat;
    logic [1:0]  cause_lat;
    logic [31:0] handler_lat;
    logic [3:0]  wait_cnt;

    logic        req_any;
    logic [1:0]  req_cause;
    logic [31:0] req_vec;
    logic        wait_last;

    // Priority encode the raw requests: opcode > div0 > overflow.
    always_comb begin
        req_any   = bus.exc_opcode | bus.exc_div0 | bus.exc_ovf;
        req_cause = CAUSE_NONE;
        req_vec   = 32'd0;
        if (bus.exc_opcode) begin
            req_cause = CAUSE_OPCODE;
            req_vec   = VEC_OPCODE;
        end else if (bus.exc_div0) begin
            req_cause = CAUSE_DIV0;
            req_vec   = VEC_DIV0;
        end else if (bus.exc_ovf) begin
            req_cause = CAUSE_OVF;
            req_vec   = VEC_OVF;
        end
    end

    assign wait_last = (wait_cnt == 4'd0);

    // State register; reset wins over any sequence in progress.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; requests are only looked at in S_IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (req_any) begin
                    state_nxt = S_SAVE_EPC;
                end
            end
            S_SAVE_EPC: state_nxt = S_MEM_RD;
            S_MEM_RD:   state_nxt = S_MEM_WAIT;
            S_MEM_WAIT: begin
                if (wait_last) begin
                    state_nxt = S_LOAD_PC;
                end
            end
            S_LOAD_PC:  state_nxt = S_DONE;
            S_DONE:     state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    // Latches taken on acceptance, the memory wait counter and the handler
    // capture. Cause and handler hold until the next accepted exception.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_lat      <= 32'd0;
            vec_lat     <= 32'd0;
            cause_lat   <= CAUSE_NONE;
            handler_lat <= 32'd0;
            wait_cnt    <= 4'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_any) begin
                        pc_lat    <= bus.pc_cur;
                        vec_lat   <= req_vec;
                        cause_lat <= req_cause;
                    end
                end
                S_MEM_RD: begin
                    wait_cnt <= WAIT_LOAD;
                end
                S_MEM_WAIT: begin
                    if (wait_last) begin
                        handler_lat <= {24'd0, bus.mem_byte};
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Output decode from the state register and the latched values only.
    always_comb begin
        bus.busy         = (state != S_IDLE);
        bus.done         = (state == S_DONE);
        bus.epc_wr       = (state == S_SAVE_EPC);
        bus.mem_rd       = (state == S_MEM_RD);
        bus.pc_wr        = (state == S_LOAD_PC);
        bus.cause        = cause_lat;
        bus.handler_addr = handler_lat;
        bus.epc_data     = 32'd0;
        bus.mem_addr     = 32'd0;
        bus.pc_src_sel   = 3'b000;
        case (state)
            S_SAVE_EPC: begin
                // Modulo-2^32 subtraction: a PC of 0 yields 32'hFFFF_FFFC.
                bus.epc_data = pc_lat - 32'd4;
            end
            S_MEM_RD, S_MEM_WAIT: begin
                bus.mem_addr = vec_lat;
            end
            S_LOAD_PC: begin
                bus.mem_addr   = vec_lat;
                bus.pc_src_sel = SEL_MEM;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_exc_vector_seq.sv
// Directed bench for exc_vector_seq. Three instances run side by side with
// MEM_WAIT = 1, 2 and 4, sharing request and PC stimulus; each has its own
// memory byte so the capture cycle can be probed per instance. Index i in
// the sequence loops is the cycle after the i-th edge following the trigger
// edge (i = 0 is the SAVE_EPC cycle, T+1).
module tb_exc_vector_seq;

    logic clk;
    logic reset;

    int vec_cnt;
    int miscompares;

    exc_vector_seq_if b1 ();
    exc_vector_seq_if b2 ();
    exc_vector_seq_if b4 ();

    exc_vector_seq #(.MEM_WAIT(1)) dut1 (.clk(clk), .reset(reset), .bus(b1));
    exc_vector_seq #(.MEM_WAIT(2)) dut2 (.clk(clk), .reset(reset), .bus(b2));
    exc_vector_seq #(.MEM_WAIT(4)) dut4 (.clk(clk), .reset(reset), .bus(b4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic op, input logic d0, input logic ov);
        b1.exc_opcode = op; b1.exc_div0 = d0; b1.exc_ovf = ov;
        b2.exc_opcode = op; b2.exc_div0 = d0; b2.exc_ovf = ov;
        b4.exc_opcode = op; b4.exc_div0 = d0; b4.exc_ovf = ov;
    endtask

    task automatic set_pc(input logic [31:0] pc);
        b1.pc_cur = pc;
        b2.pc_cur = pc;
        b4.pc_cur = pc;
    endtask

    task automatic set_mem(input logic [7:0] v);
        b1.mem_byte = v;
        b2.mem_byte = v;
        b4.mem_byte = v;
    endtask

    initial begin
        vec_cnt     = 0;
        miscompares = 0;
        reset       = 1'b0;
        set_req(1'b0, 1'b0, 1'b1);
        set_pc(32'h0000_1234);
        set_mem(8'hEE);

        // Reset held for two edges with an overflow request present.
        tick();
        tick();
        chk("rst_busy",     32'(b2.busy),       32'd0);
        chk("rst_done",     32'(b2.done),       32'd0);
        chk("rst_epc_wr",   32'(b2.epc_wr),     32'd0);
        chk("rst_epc_data", b2.epc_data,        32'd0);
        chk("rst_mem_rd",   32'(b2.mem_rd),     32'd0);
        chk("rst_mem_addr", b2.mem_addr,        32'd0);
        chk("rst_pc_wr",    32'(b2.pc_wr),      32'd0);
        chk("rst_sel",      32'(b2.pc_src_sel), 32'd0);
        chk("rst_cause",    32'(b2.cause),      32'd0);
        chk("rst_handler",  b2.handler_addr,    32'd0);
        chk("rst_busy_w1",  32'(b1.busy),       32'd0);
        chk("rst_busy_w4",  32'(b4.busy),       32'd0);
        set_req(1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        chk("idle_busy", 32'(b2.busy), 32'd0);

        // Overflow at pc 0x40; each instance's handler byte only becomes
        // valid in its capture cycle (index 1+MEM_WAIT).
        set_pc(32'h0000_0040);
        set_req(1'b0, 1'b0, 1'b1);
        tick();
        set_req(1'b0, 1'b0, 1'b0);
        for (int i = 0; i <= 8; i++) begin
            if (i == 2) b1.mem_byte = 8'h51;
            if (i == 3) b2.mem_byte = 8'h3C;
            if (i == 5) b4.mem_byte = 8'h54;
            chk($sformatf("ovf_epc_wr[%0d]", i), 32'(b2.epc_wr), 32'(i == 0));
            chk($sformatf("ovf_mem_rd[%0d]", i), 32'(b2.mem_rd), 32'(i == 1));
            chk($sformatf("ovf_mem_addr[%0d]", i), b2.mem_addr,
                (i >= 1 && i <= 4) ? 32'd254 : 32'd0);
            chk($sformatf("ovf_pc_wr[%0d]", i), 32'(b2.pc_wr), 32'(i == 4));
            chk($sformatf("ovf_sel[%0d]", i), 32'(b2.pc_src_sel),
                (i == 4) ? 32'd5 : 32'd0);
            chk($sformatf("ovf_done[%0d]", i), 32'(b2.done), 32'(i == 5));
            chk($sformatf("ovf_busy[%0d]", i), 32'(b2.busy), 32'(i <= 5));
            chk($sformatf("ovf_handler[%0d]", i), b2.handler_addr,
                (i >= 4) ? 32'h3C : 32'd0);
            chk($sformatf("w1_pc_wr[%0d]", i), 32'(b1.pc_wr), 32'(i == 3));
            chk($sformatf("w4_pc_wr[%0d]", i), 32'(b4.pc_wr), 32'(i == 6));
            chk($sformatf("w1_busy[%0d]", i), 32'(b1.busy), 32'(i <= 4));
            chk($sformatf("w4_busy[%0d]", i), 32'(b4.busy), 32'(i <= 7));
            if (i == 0) chk("ovf_epc_data", b2.epc_data, 32'h3C);
            if (i == 0) chk("ovf_cause", 32'(b2.cause), 32'd3);
            tick();
        end
        chk("w1_handler", b1.handler_addr, 32'h51);
        chk("w4_handler", b4.handler_addr, 32'h54);
        chk("ovf_cause_hold", 32'(b2.cause), 32'd3);

        // All three requests together; further requests during busy.
        set_pc(32'h0000_0100);
        set_mem(8'h77);
        set_req(1'b1, 1'b1, 1'b1);
        tick();
        set_req(1'b0, 1'b0, 1'b0);
        for (int i = 0; i <= 8; i++) begin
            if (i == 2) set_req(1'b0, 1'b1, 1'b1);
            if (i == 4) set_req(1'b0, 1'b0, 1'b0);
            chk($sformatf("pri_epc_wr[%0d]", i), 32'(b2.epc_wr), 32'(i == 0));
            if (i == 0) chk("pri_cause", 32'(b2.cause), 32'd1);
            if (i == 0) chk("pri_epc_data", b2.epc_data, 32'hFC);
            if (i == 1) chk("pri_mem_addr", b2.mem_addr, 32'd253);
            if (i == 4) chk("pri_handler", b2.handler_addr, 32'h77);
            tick();
        end
        chk("pri_cause_hold", 32'(b2.cause), 32'd1);

        // PC of zero wraps on the subtraction.
        set_pc(32'h0000_0000);
        set_req(1'b0, 1'b1, 1'b0);
        tick();
        set_req(1'b0, 1'b0, 1'b0);
        for (int i = 0; i <= 8; i++) begin
            if (i == 0) chk("wrap_epc_data", b2.epc_data, 32'hFFFF_FFFC);
            if (i == 0) chk("wrap_cause", 32'(b2.cause), 32'd2);
            if (i == 1) chk("wrap_mem_addr", b2.mem_addr, 32'd255);
            tick();
        end

        // Reset during MEM_WAIT aborts the sequence.
        set_pc(32'h0000_0080);
        set_req(1'b0, 1'b0, 1'b1);
        tick();
        set_req(1'b0, 1'b0, 1'b0);
        tick();
        tick();
        chk("abort_in_wait", b2.mem_addr, 32'd254);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("abort_busy",     32'(b2.busy),       32'd0);
        chk("abort_mem_addr", b2.mem_addr,        32'd0);
        chk("abort_cause",    32'(b2.cause),      32'd0);
        chk("abort_handler",  b2.handler_addr,    32'd0);
        chk("abort_sel",      32'(b2.pc_src_sel), 32'd0);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("abort_pc_wr[%0d]", i), 32'(b2.pc_wr), 32'd0);
            chk($sformatf("abort_w4_pc_wr[%0d]", i), 32'(b4.pc_wr), 32'd0);
            chk($sformatf("abort_epc_wr[%0d]", i), 32'(b2.epc_wr), 32'd0);
            tick();
        end

        // Level request held: one IDLE cycle between back-to-back sequences.
        set_pc(32'h0000_0200);
        set_req(1'b0, 1'b0, 1'b1);
        tick();
        for (int i = 0; i <= 8; i++) begin
            chk($sformatf("b2b_epc_wr[%0d]", i), 32'(b2.epc_wr), 32'(i == 0 || i == 7));
            chk($sformatf("b2b_busy[%0d]", i), 32'(b2.busy), 32'(i != 6));
            tick();
        end
        set_req(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) tick();
        chk("end_busy", 32'(b2.busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
        $finish;
    end

endmodule
